// File: rtl/phy_regfile_wb_pkg.sv
// Shared widths and request payload type for the regfile write-back arbiter.
package phy_regfile_wb_pkg;
   localparam int REQ_NUM          = 6;
   localparam int WB_WIDTH         = 4;
   localparam int PHY_REG_ID_WIDTH = 6;
   localparam int REG_DATA_WIDTH   = 32;
   localparam int REQ_IDX_WIDTH    = $clog2(REQ_NUM);

   typedef struct packed {
      logic [PHY_REG_ID_WIDTH-1:0] id;
      logic [REG_DATA_WIDTH-1:0]   data;
   } wb_req_t;
endpackage

// File: rtl/phy_regfile_wb_arbiter_if.sv
// Execute-unit result streams in, regfile write ports out.
interface phy_regfile_wb_arbiter_if import phy_regfile_wb_pkg::*; #(
   parameter int N_REQ = REQ_NUM,
   parameter int N_WB  = WB_WIDTH
);
   logic [N_REQ-1:0]                       req_valid;
   logic [N_REQ-1:0][PHY_REG_ID_WIDTH-1:0] req_phy_id;
   logic [N_REQ-1:0][REG_DATA_WIDTH-1:0]   req_data;
   logic [N_REQ-1:0]                       req_ready;
   logic [N_WB-1:0][PHY_REG_ID_WIDTH-1:0]  wb_phyf_id;
   logic [N_WB-1:0][REG_DATA_WIDTH-1:0]    wb_phyf_data;
   logic [N_WB-1:0]                        wb_phyf_we;

   modport master (
      output req_valid, req_phy_id, req_data,
      input  req_ready, wb_phyf_id, wb_phyf_data, wb_phyf_we
   );
   modport slave (
      input  req_valid, req_phy_id, req_data,
      output req_ready, wb_phyf_id, wb_phyf_data, wb_phyf_we
   );
endinterface

// File: rtl/phy_regfile_wb_arbiter_rr_multi_picker.sv
// Combinational rotating-priority picker: grants up to N_WB pending entries,
// never two with the same physical id in one cycle.
module rr_multi_picker import phy_regfile_wb_pkg::*; #(
   parameter int N_REQ = REQ_NUM,
   parameter int N_WB  = WB_WIDTH,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0]                       pend_valid,
   input  logic [IDX_W-1:0]                       rr_ptr,
   input  logic [N_REQ-1:0][PHY_REG_ID_WIDTH-1:0] ids,
   output logic [N_REQ-1:0]                       grant,
   output logic [N_WB-1:0][IDX_W-1:0]             port_idx,
   output logic [N_WB-1:0]                        port_vld,
   output logic [IDX_W-1:0]                       last_idx
);
   always_comb begin
      int   cnt;
      int   idx;
      logic dup;
      grant    = '0;
      port_idx = '0;
      port_vld = '0;
      last_idx = rr_ptr;
      cnt      = 0;
      for (int s = 0; s < N_REQ; s++) begin
         idx = int'(rr_ptr) + s;
         if (idx >= N_REQ) idx = idx - N_REQ;
         // A later entry hitting an id already granted waits for a later cycle.
         dup = 1'b0;
         for (int k = 0; k < N_WB; k++)
            if (port_vld[k] && ids[port_idx[k]] == ids[idx]) dup = 1'b1;
         if (pend_valid[idx] && !dup && cnt < N_WB) begin
            grant[idx]    = 1'b1;
            port_idx[cnt] = IDX_W'(idx);
            port_vld[cnt] = 1'b1;
            last_idx      = IDX_W'(idx);
            cnt           = cnt + 1;
         end
      end
   end
endmodule

// File: rtl/phy_regfile_wb_arbiter.sv
// Per-requester one-entry buffers feeding registered regfile write ports through
// the rotating multi-picker; flush drops everything pending.
module phy_regfile_wb_arbiter import phy_regfile_wb_pkg::*; #(
   parameter int N_REQ = REQ_NUM,
   parameter int N_WB  = WB_WIDTH,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   phy_regfile_wb_arbiter_if.slave  bus,
   output logic                     busy
);
   logic [N_REQ-1:0]                       pend_valid_q, pend_valid_d;
   wb_req_t [N_REQ-1:0]                    pend_q, pend_d;
   logic [IDX_W-1:0]                       rr_ptr_q, rr_ptr_d;
   logic [N_WB-1:0]                        wb_we_q, wb_we_d;
   wb_req_t [N_WB-1:0]                     wb_q, wb_d;
   logic [N_REQ-1:0][PHY_REG_ID_WIDTH-1:0] pend_ids;
   logic [N_REQ-1:0]                       grant;
   logic [N_WB-1:0][IDX_W-1:0]             port_idx;
   logic [N_WB-1:0]                        port_vld;
   logic [IDX_W-1:0]                       last_idx;

   always_comb begin
      pend_ids = '0;
      for (int i = 0; i < N_REQ; i++) pend_ids[i] = pend_q[i].id;
   end

   rr_multi_picker #(.N_REQ(N_REQ), .N_WB(N_WB)) u_picker (
      .pend_valid (pend_valid_q),
      .rr_ptr     (rr_ptr_q),
      .ids        (pend_ids),
      .grant      (grant),
      .port_idx   (port_idx),
      .port_vld   (port_vld),
      .last_idx   (last_idx)
   );

   // A buffer being drained this cycle can take the next result in the same cycle.
   assign bus.req_ready = {N_REQ{rst & ~flush}} & (~pend_valid_q | grant);

   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_d       = pend_q;
      rr_ptr_d     = rr_ptr_q;
      wb_we_d      = '0;
      wb_d         = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (bus.req_valid[i] && bus.req_ready[i]) begin
            pend_valid_d[i] = 1'b1;
            pend_d[i]       = '{id: bus.req_phy_id[i], data: bus.req_data[i]};
         end else if (grant[i]) begin
            pend_valid_d[i] = 1'b0;
         end
      end
      for (int k = 0; k < N_WB; k++) begin
         if (port_vld[k]) begin
            wb_we_d[k] = 1'b1;
            wb_d[k]    = pend_q[port_idx[k]];
         end
      end
      if (|port_vld)
         rr_ptr_d = (last_idx == IDX_W'(N_REQ-1)) ? '0 : last_idx + 1'b1;
      if (flush) begin
         pend_valid_d = '0;
         wb_we_d      = '0;
         wb_d         = '0;
         rr_ptr_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pend_valid_q <= '0;
         pend_q       <= '0;
         rr_ptr_q     <= '0;
         wb_we_q      <= '0;
         wb_q         <= '0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_q       <= pend_d;
         rr_ptr_q     <= rr_ptr_d;
         wb_we_q      <= wb_we_d;
         wb_q         <= wb_d;
      end
   end

   always_comb begin
      bus.wb_phyf_id   = '0;
      bus.wb_phyf_data = '0;
      for (int k = 0; k < N_WB; k++) begin
         bus.wb_phyf_id[k]   = wb_q[k].id;
         bus.wb_phyf_data[k] = wb_q[k].data;
      end
   end

   assign bus.wb_phyf_we = wb_we_q;
   assign busy           = |pend_valid_q | |wb_we_q;
endmodule

// File: tb/tb_phy_regfile_wb_arbiter.sv
// Scoreboard bench: stimulus queues expected {port,id,data} writes, a negedge
// monitor pops one entry per active write port and checks it.
module tb_phy_regfile_wb_arbiter;
   import phy_regfile_wb_pkg::*;

   typedef struct {
      int                          port;
      logic [PHY_REG_ID_WIDTH-1:0] id;
      logic [REG_DATA_WIDTH-1:0]   data;
   } exp_t;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic flush = 1'b0;
   logic busy;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   phy_regfile_wb_arbiter_if ifc ();

   phy_regfile_wb_arbiter dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (ifc.slave),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int i, input int id, input int data);
      ifc.req_valid[i]  = 1'b1;
      ifc.req_phy_id[i] = PHY_REG_ID_WIDTH'(id);
      ifc.req_data[i]   = REG_DATA_WIDTH'(data);
   endtask

   task automatic push(input int port, input int id, input int data);
      exp_t e;
      e.port = port;
      e.id   = PHY_REG_ID_WIDTH'(id);
      e.data = REG_DATA_WIDTH'(data);
      exp_q.push_back(e);
   endtask

   // Monitor: every asserted write port must match the next expected write.
   always @(negedge clk) begin
      for (int k = 0; k < WB_WIDTH; k++) begin
         if (ifc.wb_phyf_we[k] === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL wb_unexpected: port %0d id %0d data %0h with nothing expected",
                        k, ifc.wb_phyf_id[k], ifc.wb_phyf_data[k]);
            end else begin
               mon_e = exp_q.pop_front();
               chk("wb_port", 64'(k), 64'(mon_e.port));
               chk("wb_id",   64'(ifc.wb_phyf_id[k]),   64'(mon_e.id));
               chk("wb_data", 64'(ifc.wb_phyf_data[k]), 64'(mon_e.data));
            end
         end
      end
      for (int a = 0; a < WB_WIDTH; a++)
         for (int b = a + 1; b < WB_WIDTH; b++)
            if (ifc.wb_phyf_we[a] === 1'b1 && ifc.wb_phyf_we[b] === 1'b1)
               chk("wb_same_id_pair", 64'(ifc.wb_phyf_id[a] == ifc.wb_phyf_id[b]), 64'd0);
   end

   initial begin
      ifc.req_valid  = '1;
      ifc.req_phy_id = '0;
      ifc.req_data   = '0;

      // Reset held with all requesters asserting valid
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_ready", 64'(ifc.req_ready), 64'd0);
         chk("rst_we",    64'(ifc.wb_phyf_we), 64'd0);
         chk("rst_busy",  64'(busy), 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      ifc.req_valid = '0;
      @(negedge clk);
      chk("post_rst_ready", 64'(ifc.req_ready), 64'h3f);

      // Single result: two-cycle latency
      @(posedge clk); #1;
      drive(0, 5, 32'hDEAD);
      push(0, 5, 32'hDEAD);
      @(posedge clk); #1;
      ifc.req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      chk("single_we",   64'(ifc.wb_phyf_we), 64'b0001);
      chk("single_id",   64'(ifc.wb_phyf_id[0]), 64'd5);
      chk("single_data", 64'(ifc.wb_phyf_data[0]), 64'hDEAD);
      repeat (3) @(posedge clk);

      // Flush to bring rr_ptr back to 0, then overload with all six
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      for (int i = 0; i < REQ_NUM; i++) drive(i, 10 + i, 32'h100 + i);
      for (int i = 0; i < 4; i++) push(i, 10 + i, 32'h100 + i);
      push(0, 14, 32'h104);
      push(1, 15, 32'h105);
      @(posedge clk); #1;
      ifc.req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      chk("ovl_we_first", 64'(ifc.wb_phyf_we), 64'b1111);
      @(negedge clk);
      chk("ovl_we_second", 64'(ifc.wb_phyf_we), 64'b0011);
      repeat (3) @(posedge clk);

      // Duplicate id: req1 written before req3, in separate cycles
      #1;
      drive(1, 9, 32'hA1);
      drive(3, 9, 32'hA3);
      push(0, 9, 32'hA1);
      push(0, 9, 32'hA3);
      @(posedge clk); #1;
      ifc.req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      chk("dup_we_first", 64'(ifc.wb_phyf_we), 64'b0001);
      @(negedge clk);
      chk("dup_we_second", 64'(ifc.wb_phyf_we), 64'b0001);
      repeat (3) @(posedge clk);

      // Flush with four pending
      #1;
      for (int i = 0; i < 4; i++) drive(i, 20 + i, 32'h200 + i);
      @(posedge clk); #1;
      ifc.req_valid = '0;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_ready", 64'(ifc.req_ready), 64'd0);
      chk("flush_busy_before", 64'(busy), 64'd1);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_we", 64'(ifc.wb_phyf_we), 64'd0);
      chk("flush_busy_after", 64'(busy), 64'd0);
      // rr_ptr back at 0: req0 must land on port 0 ahead of req4
      @(posedge clk); #1;
      drive(0, 31, 32'h31);
      drive(4, 30, 32'h30);
      push(0, 31, 32'h31);
      push(1, 30, 32'h30);
      @(posedge clk); #1;
      ifc.req_valid = '0;
      repeat (4) @(posedge clk);

      // Back-to-back: req2 every cycle
      for (int n = 0; n < 10; n++) begin
         #1;
         drive(2, 40 + n, 32'h2000 + n);
         push(0, 40 + n, 32'h2000 + n);
         @(negedge clk);
         chk("b2b_ready", 64'(ifc.req_ready[2]), 64'd1);
         @(posedge clk);
      end
      #1 ifc.req_valid = '0;
      repeat (4) @(posedge clk);

      // Reset mid-operation drops a pending result
      #1 drive(5, 50, 32'h5050);
      @(posedge clk); #1;
      ifc.req_valid = '0;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready", 64'(ifc.req_ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("midrst_busy", 64'(busy), 64'd0);

      for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
      chk("drain_remaining", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
